// File: rtl/axi_sd_regbank_pkg.sv
// Shared constants and helpers for the AXI4-Lite register bank.
package axi_sd_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Word index of a byte address; byte-lane bits below lsb are dropped.
    function automatic int unsigned word_index(input logic [63:0] addr, input int unsigned lsb);
        return 32'(addr >> lsb);
    endfunction

endpackage

// File: rtl/axi_sd_regbank_if.sv
// AXI4-Lite slave-port bundle for the register bank.
interface axi_sd_regbank_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DW     = 32
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA;
    logic [DW/8-1:0]   S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_sd_regbank_reg_cell.sv
// One control register: byte-strobed write, optional write-1-to-clear with hardware set.
module axi_sd_reg_cell #(
    parameter int unsigned     DW        = 32,
    parameter bit              W1C       = 1'b0,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_we,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic [DW-1:0]   i_hw_set,
    output logic [DW-1:0]   o_q
);
    localparam int unsigned NB = DW / 8;

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_q_nxt;

    // Next value: strobed bytes replaced or cleared, then hw_set ORed last so set beats clear.
    always_comb begin
        w_q_nxt = r_q;
        if (i_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (i_wstrb[b]) begin
                    if (W1C) w_q_nxt[b*8 +: 8] = r_q[b*8 +: 8] & ~i_wdata[b*8 +: 8];
                    else     w_q_nxt[b*8 +: 8] = i_wdata[b*8 +: 8];
                end
            end
        end
        if (W1C) w_q_nxt = w_q_nxt | i_hw_set;
    end

    // Register state.
    always_ff @(posedge clock) begin
        if (reset) r_q <= RESET_VAL;
        else       r_q <= w_q_nxt;
    end

    assign o_q = r_q;
endmodule

// File: rtl/axi_sd_regbank.sv
// AXI4-Lite slave register bank: NUM_RW control registers followed by NUM_RO status words.
module axi_sd_regbank
    import axi_sd_pkg::*;
#(
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned                   NUM_RW             = 8,
    parameter int unsigned                   NUM_RO             = 4,
    parameter logic [NUM_RW-1:0]             W1C_MASK           = '0,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL          = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    axi_sd_regbank_if.slave                      s_axi,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    input  logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] hw_set,
    output logic [NUM_RW-1:0]                    wr_pulse
);
    localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned LSB = clog2(NB);
    localparam int unsigned NW  = NUM_RW + NUM_RO;

    logic          r_aw_held, r_w_held;
    logic [AW-1:0] r_aw_addr;
    logic [DW-1:0] r_w_data;
    logic [NB-1:0] r_w_strb;
    logic          r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]    r_bresp, r_rresp;
    logic [DW-1:0] r_rdata;
    logic [NUM_RW-1:0] r_wr_pulse;

    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data, w_rd_data;
    logic [NB-1:0] w_wr_strb;
    int unsigned   w_wr_idx, w_rd_idx;
    logic [NUM_RW-1:0] w_we;

    logic          w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
    logic [1:0]    w_bresp_nxt, w_rresp_nxt;
    logic [DW-1:0] w_rdata_nxt;
    logic          w_unused;

    assign w_aw_hs = s_axi.S_AXI_AWVALID && r_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  && r_wready;
    assign w_ar_hs = s_axi.S_AXI_ARVALID && r_arready;

    // A held half is completed by the other half's handshake on the same edge.
    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axi.S_AXI_AWADDR;
    assign w_wr_data = r_w_held  ? r_w_data  : s_axi.S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_w_strb  : s_axi.S_AXI_WSTRB;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_idx  = word_index(64'(w_wr_addr), LSB);
    assign w_wr_ok   = w_wr_idx < NUM_RW;
    assign w_rd_idx  = word_index(64'(s_axi.S_AXI_ARADDR), LSB);
    assign w_rd_ok   = w_rd_idx < NW;

    // Control register array.
    for (genvar k = 0; k < NUM_RW; k++) begin : g_reg
        assign w_we[k] = w_commit && (w_wr_idx == k);
        axi_sd_reg_cell #(
            .DW        (DW),
            .W1C       (W1C_MASK[k]),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clock    (clock),
            .reset    (reset),
            .i_we     (w_we[k]),
            .i_wdata  (w_wr_data),
            .i_wstrb  (w_wr_strb),
            .i_hw_set (hw_set[k*DW +: DW]),
            .o_q      (reg_out[k*DW +: DW])
        );
    end

    // Read mux as an OR chain over all words; out-of-range matches nothing and yields 0.
    for (genvar k = 0; k < NW; k++) begin : g_rd
        logic [DW-1:0] w_val, w_acc;
        if (k < NUM_RW) begin : g_rw
            assign w_val = reg_out[k*DW +: DW];
        end else begin : g_ro
            assign w_val = reg_in[(k-NUM_RW)*DW +: DW];
        end
        if (k == 0) begin : g_first
            assign w_acc = (w_rd_idx == k) ? w_val : '0;
        end else begin : g_next
            assign w_acc = g_rd[k-1].w_acc | ((w_rd_idx == k) ? w_val : '0);
        end
    end
    assign w_rd_data = g_rd[NW-1].w_acc;

    // Next-state for holds and response channels.
    always_comb begin
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_rvalid_nxt  = r_rvalid;
        w_rresp_nxt   = r_rresp;
        w_rdata_nxt   = r_rdata;
        if (w_aw_hs) w_aw_held_nxt = 1'b1;
        if (w_w_hs)  w_w_held_nxt  = 1'b1;
        if (r_bvalid && s_axi.S_AXI_BREADY) w_bvalid_nxt = 1'b0;
        if (w_commit) begin
            w_aw_held_nxt = 1'b0;
            w_w_held_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b1;
            w_bresp_nxt   = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
        if (r_rvalid && s_axi.S_AXI_RREADY) w_rvalid_nxt = 1'b0;
        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
            w_rdata_nxt  = w_rd_data;
            w_rresp_nxt  = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Channel state, holding registers and registered READY/pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            if (w_aw_hs) r_aw_addr <= s_axi.S_AXI_AWADDR;
            if (w_w_hs) begin
                r_w_data <= s_axi.S_AXI_WDATA;
                r_w_strb <= s_axi.S_AXI_WSTRB;
            end
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_awready  <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready   <= !w_w_held_nxt && !w_bvalid_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_arready  <= !w_rvalid_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rdata    <= w_rdata_nxt;
            r_wr_pulse <= w_we;
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign wr_pulse            = r_wr_pulse;

    // Protection bits carry no meaning for this slave.
    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
endmodule

// File: tb/tb_axi_sd_regbank.sv
// Directed self-checking bench for axi_sd_regbank (register 0 configured write-1-to-clear).
module tb_axi_sd_regbank;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 6;
    localparam int unsigned NRW = 8;
    localparam int unsigned NRO = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NRW*DW-1:0] reg_out;
    logic [NRO*DW-1:0] reg_in;
    logic [NRW*DW-1:0] hw_set;
    logic [NRW-1:0]    wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_sd_regbank_if #(.ADDR_W(AW), .DW(DW)) bus ();

    axi_sd_regbank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_RW             (NRW),
        .NUM_RO             (NRO),
        .W1C_MASK           (8'h01),
        .RESET_VAL          (32'h0)
    ) dut (
        .clock    (clk),
        .reset    (rst),
        .s_axi    (bus),
        .reg_out  (reg_out),
        .reg_in   (reg_in),
        .hw_set   (hw_set),
        .wr_pulse (wr_pulse)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write with BREADY high; returns response and every wr_pulse bit seen.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [7:0] pulses);
        bit aw_done, w_done, aw_now, w_now;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = data;  bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk);
            aw_now = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_now  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            tick();
            cyc++;
            if (aw_now) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done = 1;  bus.S_AXI_WVALID = 1'b0; end
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("wr_accepted", 256'(aw_done && w_done), 256'(1));
        check("wr_bvalid_latency", 256'(bus.S_AXI_BVALID), 256'(1));
        resp = bus.S_AXI_BRESP;
        pulses = wr_pulse;
        tick();
        pulses = pulses | wr_pulse;
        check("wr_bvalid_cleared", 256'(bus.S_AXI_BVALID), 256'(0));
    endtask

    // Full read with RREADY high.
    task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done, now;
        int cyc;
        done = 0; cyc = 0;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            now = bus.S_AXI_ARREADY;
            tick();
            cyc++;
            if (now) begin done = 1; bus.S_AXI_ARVALID = 1'b0; end
        end
        bus.S_AXI_ARVALID = 1'b0;
        check("rd_rvalid_latency", 256'(bus.S_AXI_RVALID), 256'(1));
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        tick();
        check("rd_rvalid_cleared", 256'(bus.S_AXI_RVALID), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulses;
        logic [31:0] rdata;

        rst = 1'b1;
        hw_set = '0;
        reg_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'hCAFEF00D};
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = 3'b0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;    bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = 3'b0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_awready", 256'(bus.S_AXI_AWREADY), 256'(0));
        check("rst_wready",  256'(bus.S_AXI_WREADY),  256'(0));
        check("rst_arready", 256'(bus.S_AXI_ARREADY), 256'(0));
        check("rst_bvalid",  256'(bus.S_AXI_BVALID),  256'(0));
        check("rst_rvalid",  256'(bus.S_AXI_RVALID),  256'(0));
        check("rst_rdata",   256'(bus.S_AXI_RDATA),   256'(0));
        check("rst_reg_out", reg_out, 256'(0));
        check("rst_wr_pulse", 256'(wr_pulse), 256'(0));
        rst = 1'b0;
        tick();
        check("awready_after_reset", 256'(bus.S_AXI_AWREADY), 256'(1));

        // Byte strobes: bytes 0 and 2 of word 2
        do_write(6'h08, 32'hAABBCCDD, 4'b0101, resp, pulses);
        check("strb_bresp", 256'(resp), 256'(2'b00));
        check("strb_pulse", 256'(pulses), 256'(8'h04));
        do_read(6'h08, rdata, resp);
        check("strb_rdata", 256'(rdata), 256'(32'h00BB00DD));

        // Write 1..8 to words 0..7; word 0 is W1C so clearing bit 0 of zero leaves 0
        for (int k = 0; k < 8; k++) begin
            do_write(6'(k * 4), 32'(k + 1), 4'hF, resp, pulses);
            check("seq_bresp", 256'(resp), 256'(2'b00));
            check("seq_pulse", 256'(pulses), 256'(8'h01) << k);
        end
        for (int k = 0; k < 8; k++) begin
            do_read(6'(k * 4), rdata, resp);
            check("seq_rdata", 256'(rdata), (k == 0) ? 256'(0) : 256'(k + 1));
            check("seq_rresp", 256'(resp), 256'(2'b00));
        end
        check("seq_reg_out", reg_out,
              {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd0});

        // W arrives 3 cycles before AW, then B is stalled for 5 cycles
        bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0;
        check("late_aw_wready", 256'(bus.S_AXI_WREADY), 256'(1));
        tick();
        bus.S_AXI_WVALID = 1'b0;
        check("late_aw_no_b_t1", 256'(bus.S_AXI_BVALID), 256'(0));
        tick();
        tick();
        bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
        check("late_aw_no_b_t3", 256'(bus.S_AXI_BVALID), 256'(0));
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check("late_aw_bvalid_t4", 256'(bus.S_AXI_BVALID), 256'(1));
        check("late_aw_pulse", 256'(wr_pulse), 256'(8'h08));
        check("late_aw_reg3", 256'(reg_out[3*DW +: DW]), 256'(32'h12345678));
        for (int i = 0; i < 5; i++) begin
            check("stall_awready", 256'(bus.S_AXI_AWREADY), 256'(0));
            check("stall_wready",  256'(bus.S_AXI_WREADY),  256'(0));
            check("stall_bvalid",  256'(bus.S_AXI_BVALID),  256'(1));
            tick();
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        check("stall_released", 256'(bus.S_AXI_BVALID), 256'(0));

        // W1C: set via hw_set (plain word 1 must ignore it), clear with 0x0F
        hw_set[31:0]  = 32'h000000FF;
        hw_set[63:32] = 32'hFFFFFFFF;
        tick();
        hw_set = '0;
        check("w1c_hw_set", 256'(reg_out[31:0]), 256'(32'hFF));
        check("plain_ignores_hw_set", 256'(reg_out[63:32]), 256'(32'h2));
        do_write(6'h00, 32'h0000000F, 4'hF, resp, pulses);
        do_read(6'h00, rdata, resp);
        check("w1c_clear", 256'(rdata), 256'(32'hF0));

        // Set and clear on bit 0 in the same commit cycle: set wins
        bus.S_AXI_AWADDR = 6'h00; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h1; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        hw_set[31:0] = 32'h1;
        check("w1c_set_ready", 256'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 256'(2'b11));
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        hw_set = '0;
        check("w1c_set_wins", 256'(reg_out[31:0]), 256'(32'hF1));
        tick();
        do_read(6'h00, rdata, resp);
        check("w1c_set_readback", 256'(rdata), 256'(32'hF1));

        // Error and status accesses
        do_write(6'h24, 32'hDEADBEEF, 4'hF, resp, pulses);
        check("ro_wr_slverr", 256'(resp), 256'(2'b10));
        check("ro_wr_no_pulse", 256'(pulses), 256'(0));
        do_read(6'h34, rdata, resp);
        check("oor_rd_data", 256'(rdata), 256'(0));
        check("oor_rd_slverr", 256'(resp), 256'(2'b10));
        do_read(6'h20, rdata, resp);
        check("status8_data", 256'(rdata), 256'(32'hCAFEF00D));
        check("status8_okay", 256'(resp), 256'(2'b00));
        do_read(6'h2C, rdata, resp);
        check("status11_data", 256'(rdata), 256'(32'h44444444));
        do_read(6'h0E, rdata, resp);
        check("low_bits_ignored", 256'(rdata), 256'(32'h12345678));

        // Reset while a response is pending
        bus.S_AXI_AWADDR = 6'h10; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h9; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("pre_rst_bvalid", 256'(bus.S_AXI_BVALID), 256'(1));
        rst = 1'b1;
        tick();
        check("mid_rst_bvalid", 256'(bus.S_AXI_BVALID), 256'(0));
        check("mid_rst_reg_out", reg_out, 256'(0));
        check("mid_rst_awready", 256'(bus.S_AXI_AWREADY), 256'(0));
        rst = 1'b0;
        tick();
        do_write(6'h14, 32'h55, 4'hF, resp, pulses);
        check("post_rst_bresp", 256'(resp), 256'(2'b00));
        check("post_rst_pulse", 256'(pulses), 256'(8'h20));
        do_read(6'h14, rdata, resp);
        check("post_rst_rdata", 256'(rdata), 256'(32'h55));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
